countdown_timer: RTL

Loadable down-counter that complements the free-running up-counter: it is armed with a period, decrements on each enabled cycle, and emits a single-cycle expiry pulse when it reaches zero. It sits beside the up-counter in timing and control paths, such as watchdogs, timeouts and periodic ticks, where a deadline is needed rather than an elapsed count.

---
 rtl/countdown_timer_pkg.sv | 11 +
 rtl/countdown_timer.sv | 107 ++++++++++
 2 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the loadable down-counter (countdown_timer).
package countdown_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned COUNT_RESET = 0;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a registered single-cycle expiry pulse.
// Define COUNTDOWN_TIMER_RELOAD_EN to honour i_periodic (auto-reload); otherwise every count is one-shot.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_en,
  input  logic             i_abort,
  input  logic             i_periodic,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_expire
);

  localparam logic [WIDTH-1:0] COUNT_ZERO = WIDTH'(COUNT_RESET);
  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;

`ifdef COUNTDOWN_TIMER_RELOAD_EN
  logic periodic_q, periodic_d;
`else
  logic unused_periodic;
  assign unused_periodic = i_periodic;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      count_q    <= COUNT_ZERO;
      reload_q   <= COUNT_ZERO;
      expire_q   <= 1'b0;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
      periodic_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      expire_q   <= expire_d;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
      periodic_q <= periodic_d;
`endif
    end
  end

  // Priority: abort > start > decrement; a start edge never produces the pending expiry.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    expire_d   = 1'b0;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
    periodic_d = periodic_q;
`endif
    if (i_abort) begin
      state_d = IDLE;
      count_d = COUNT_ZERO;
    end else if (i_start) begin
      if (i_period != COUNT_ZERO) begin
        state_d    = RUN;
        count_d    = i_period;
        reload_d   = i_period;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
        periodic_d = i_periodic;
`endif
      end else begin
        state_d    = IDLE;
        count_d    = COUNT_ZERO;
        expire_d   = 1'b1;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
        periodic_d = 1'b0;
`endif
      end
    end else if (state_q == RUN && i_en) begin
      if (count_q == COUNT_ONE) begin
        expire_d = 1'b1;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
        if (periodic_q) begin
          count_d = reload_q;
        end else begin
          count_d = COUNT_ZERO;
          state_d = IDLE;
        end
`else
        count_d = COUNT_ZERO;
        state_d = IDLE;
`endif
      end else if (count_q > COUNT_ONE) begin
        count_d = count_q - COUNT_ONE;
      end
    end
  end

  assign o_count  = count_q;
  assign o_busy   = (state_q == RUN);
  assign o_expire = expire_q;

endmodule
